// File: rtl/adder_arb_pkg.sv
// Shared types and default sizing for the adder arbiter.
package adder_arb_pkg;

  localparam int unsigned PROC_SIZE_DEF  = 16;
  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned ADD_CYCLES_DEF = 2;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder; the carry chain is allowed several cycles to settle.
module ripple_carry_adder #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[W];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder among NUM_REQ requesters.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned PROC_SIZE  = PROC_SIZE_DEF,
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned ADD_CYCLES = ADD_CYCLES_DEF,
  parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*PROC_SIZE-1:0] a_in,
  input  logic [NUM_REQ*PROC_SIZE-1:0] b_in,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         busy,
  output logic                         res_valid,
  output logic [ID_W-1:0]              res_id,
  output logic [PROC_SIZE-1:0]         res_sum,
  output logic                         res_cout
);

  localparam int unsigned CntW = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;

  arb_state_t           state_q, state_d;
  logic [ID_W-1:0]      last_id_q, last_id_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [PROC_SIZE-1:0] a_q, a_d, b_q, b_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 res_valid_q, res_valid_d;
  logic [ID_W-1:0]      res_id_q, res_id_d;
  logic [PROC_SIZE-1:0] res_sum_q, res_sum_d;
  logic                 res_cout_q, res_cout_d;

  logic [PROC_SIZE-1:0] add_sum;
  logic                 add_cout;
  logic [ID_W-1:0]      win;
  int unsigned          base;

  // First requester found searching upward from last+1, wrapping.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    int unsigned     idx;
    pick = last;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (r[idx[ID_W-1:0]]) pick = idx[ID_W-1:0];
    end
    return pick;
  endfunction

  // a_q/b_q -> res_sum is a multicycle path of ADD_CYCLES cycles.
  ripple_carry_adder #(
    .W(PROC_SIZE)
  ) u_adder (
    .a   (a_q),
    .b   (b_q),
    .cin (1'b0),
    .sum (add_sum),
    .cout(add_cout)
  );

  always_comb begin
    state_d     = state_q;
    last_id_d   = last_id_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    gnt_d       = '0;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    win         = rr_pick(req, last_id_q);
    base        = int'(win) * PROC_SIZE;

    case (state_q)
      StIdle: begin
        if (|req) begin
          a_d       = a_in[base +: PROC_SIZE];
          b_d       = b_in[base +: PROC_SIZE];
          gnt_d     = NUM_REQ'(1) << win;
          last_id_d = win;
          id_d      = win;
          cnt_d     = '0;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ADD_CYCLES - 1)) begin
          res_sum_d   = add_sum;
          res_cout_d  = add_cout;
          res_id_d    = id_q;
          res_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      last_id_q   <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q == StBusy);
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed and randomized checks of adder_arbiter against a round-robin/arith model.
module tb_adder_arbiter;

  localparam int unsigned PW = 16;
  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*PW-1:0] a_in, b_in;
  logic [NR-1:0]    gnt;
  logic             busy, res_valid, res_cout;
  logic [IW-1:0]    res_id;
  logic [PW-1:0]    res_sum;

  int checks   = 0;
  int failures = 0;
  int last_m;

  always #5 clk = ~clk;

  adder_arbiter #(
    .PROC_SIZE (PW),
    .NUM_REQ   (NR),
    .ADD_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .a_in     (a_in),
    .b_in     (b_in),
    .gnt      (gnt),
    .busy     (busy),
    .res_valid(res_valid),
    .res_id   (res_id),
    .res_sum  (res_sum),
    .res_cout (res_cout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner: first requester searching from last+1 upward, wrapping.
  function automatic int rr_model(input logic [NR-1:0] mask, input int last);
    for (int k = 1; k <= int'(NR); k++) begin
      if (mask[(last + k) % NR]) return (last + k) % NR;
    end
    return last;
  endfunction

  // Issue one request pattern from IDLE, drop req after grant, check the whole transaction.
  task automatic do_op(input string tag, input logic [NR-1:0] mask,
                       input logic [NR*PW-1:0] av, input logic [NR*PW-1:0] bv);
    int          w;
    logic [16:0] full;
    req  = mask;
    a_in = av;
    b_in = bv;
    w    = rr_model(mask, last_m);
    full = {1'b0, av[w*PW +: PW]} + {1'b0, bv[w*PW +: PW]};
    tick();
    chk({tag, ".gnt"}, 32'(gnt), 32'(1) << w);
    chk({tag, ".busy1"}, 32'(busy), 32'd1);
    req = '0;
    tick();
    chk({tag, ".gnt_off"}, 32'(gnt), 32'd0);
    chk({tag, ".early_valid"}, 32'(res_valid), 32'd0);
    tick();
    chk({tag, ".valid"}, 32'(res_valid), 32'd1);
    chk({tag, ".id"}, 32'(res_id), 32'(w));
    chk({tag, ".sum"}, 32'(res_sum), 32'(full[15:0]));
    chk({tag, ".cout"}, 32'(res_cout), 32'(full[16]));
    chk({tag, ".busy0"}, 32'(busy), 32'd0);
    last_m = w;
  endtask

  initial begin
    logic [NR*PW-1:0] av, bv;
    logic [NR-1:0]    m;

    // 1: reset values and quiet idle
    rst  = 1'b1;
    req  = '0;
    a_in = '0;
    b_in = '0;
    last_m = NR - 1;
    #12;
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.valid", 32'(res_valid), 32'd0);
    chk("rst.id", 32'(res_id), 32'd0);
    chk("rst.sum", 32'(res_sum), 32'd0);
    chk("rst.cout", 32'(res_cout), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle.gnt", 32'(gnt), 32'd0);
      chk("idle.valid", 32'(res_valid), 32'd0);
    end

    // 2: single request on requester 1, then result holds
    do_op("r1", 4'b0010, 64'h0000_0000_0001_0000, 64'h0000_0000_0002_0000);
    tick();
    chk("hold.valid", 32'(res_valid), 32'd0);
    chk("hold.sum", 32'(res_sum), 32'h3);
    chk("hold.id", 32'(res_id), 32'd1);

    // 3: overflow corners on requester 0
    do_op("ovf0", 4'b0001, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001);
    do_op("ovf1", 4'b0001, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_8000);
    do_op("ovf2", 4'b0001, 64'h0000_0000_0000_1111, 64'h0000_0000_0000_1111);

    // 4: all requests held continuously from a fresh reset
    rst = 1'b1;
    #2;
    rst = 1'b0;
    last_m = NR - 1;
    req  = 4'b1111;
    a_in = {16'h3, 16'h2, 16'h1, 16'h0};
    b_in = {4{16'h0010}};
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr.gnt", 32'(gnt), 32'(1) << (k % 4));
      tick();
      chk("rr.gap", 32'(gnt), 32'd0);
      tick();
      chk("rr.gap2", 32'(gnt), 32'd0);
      chk("rr.valid", 32'(res_valid), 32'd1);
      chk("rr.id", 32'(res_id), 32'(k % 4));
      chk("rr.sum", 32'(res_sum), 32'h10 + 32'(k % 4));
    end
    req = '0;
    last_m = 0;
    tick();

    // 5: reset one cycle after a grant to requester 2
    req  = 4'b0100;
    a_in = {16'h0, 16'h1234, 16'h0, 16'h0};
    b_in = {16'h0, 16'h1111, 16'h0, 16'h0};
    tick();
    chk("rmid.gnt", 32'(gnt), 32'b0100);
    req = '0;
    tick();
    rst = 1'b1;
    #1;
    chk("rmid.busy", 32'(busy), 32'd0);
    chk("rmid.valid", 32'(res_valid), 32'd0);
    chk("rmid.sum", 32'(res_sum), 32'd0);
    #1;
    rst = 1'b0;
    last_m = NR - 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rmid.novalid", 32'(res_valid), 32'd0);
      chk("rmid.idle", 32'(busy), 32'd0);
    end
    do_op("rmid.next", 4'b1111, {16'h4, 16'h3, 16'h2, 16'h1}, {16'h40, 16'h30, 16'h20, 16'h10});

    // 6: requester 3 pulses during BUSY only; requester 1 held across
    req  = 4'b0100;
    a_in = {16'h9, 16'h5, 16'h7, 16'h0};
    b_in = {16'h9, 16'h6, 16'h8, 16'h0};
    tick();
    chk("wd.gnt2", 32'(gnt), 32'b0100);
    req = 4'b1010;
    tick();
    chk("wd.busy_gnt", 32'(gnt), 32'd0);
    req = 4'b0010;
    tick();
    chk("wd.valid", 32'(res_valid), 32'd1);
    chk("wd.sum2", 32'(res_sum), 32'd11);
    chk("wd.gnt_none", 32'(gnt), 32'd0);
    last_m = 2;
    do_op("wd.r1", 4'b0010, a_in, b_in);

    // Randomized requests and operands against the model
    for (int n = 0; n < 40; n++) begin
      m  = 4'($urandom_range(1, 15));
      av = {$urandom, $urandom};
      bv = {$urandom, $urandom};
      if (n % 5 == 0) av[PW-1:0] = 16'hFFFF;
      do_op("rand", m, av, bv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one `ripple_carry_adder` instance among `NUM_REQ` requesters. It captures the winning requester's operands into registers and holds them stable while the ripple-carry chain settles over `ADD_CYCLES` cycles, treated as a multicycle path. It then returns a registered sum and carry, tagged with the requester index. It sits between the processor-side clients and the shared adder datapath.

## Interface
- `PROC_SIZE`, 16: operand and sum width in bits.
- `NUM_REQ`, 4: number of requesters, ≥2.
- `ADD_CYCLES`, 2: cycles operands are held before the result is sampled, ≥1.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester index (derived).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request level.
- `a_in`  in  NUM_REQ*PROC_SIZE  flattened operand A; requester i uses slice [i*PROC_SIZE +: PROC_SIZE].
- `b_in`  in  NUM_REQ*PROC_SIZE  flattened operand B, same slicing.
- `gnt`  out  NUM_REQ  one-hot grant pulse, registered.
- `busy`  out  1  high while an addition is in flight.
- `res_valid`  out  1  one-cycle result strobe.
- `res_id`  out  ID_W  index of the requester owning the result.
- `res_sum`  out  PROC_SIZE  sum, modulo 2^PROC_SIZE.
- `res_cout`  out  1  carry out of the MSB.

## Operation
- FSM states: IDLE and BUSY. Reset state is IDLE.
- **IDLE, `req`≠0:**
  - Select the winner by round-robin search, starting at `last_id+1` and wrapping modulo `NUM_REQ`.
  - Latch the winner's `a_in`/`b_in` slices into `a_q`/`b_q`.
  - Set `gnt` one-hot for exactly one cycle.
  - Set `last_id` and `id_q` to the winner; clear `cnt`; go to BUSY.
- **IDLE, `req`=0:** stay in IDLE; `gnt`=0.
- **BUSY:**
  - The adder inputs are driven only from `a_q`/`b_q`.
  - `cnt` increments each cycle.
  - On the edge where `cnt`==ADD_CYCLES-1: register the adder's sum/cout into `res_sum`/`res_cout`, set `res_id`=`id_q`, pulse `res_valid`, and go to IDLE.
- **Requester contract:**
  - Hold `req` and operands stable until `gnt` is seen.
  - Deassert `req` in the cycle `gnt` is high unless another operation is wanted.
  - A `req` still high after its grant is treated as a new request.
- `req` changes during BUSY are ignored; non-granted requests simply remain pending.
- A request withdrawn before it is granted is never served. No queue is kept.
- `res_sum`, `res_cout` and `res_id` hold their values between completions.
- **Reset (any time, including mid-BUSY):**
  - state=IDLE; `last_id`=NUM_REQ-1, so requester 0 has first priority.
  - `gnt`, `busy`, `res_valid`, `res_id`, `res_sum`, `res_cout`, `cnt`, `a_q`, `b_q` = 0.
  - An in-flight operation is dropped with no `res_valid`.

## Timing
- Request sampled at edge E0 (IDLE) → `gnt` high during cycle E0..E0+1; `busy` rises at E0.
- Result registered at edge E0+ADD_CYCLES → `res_valid` high for that single cycle; `busy` falls at the same edge.
- Earliest next grant at edge E0+ADD_CYCLES+1. Throughput is one addition per ADD_CYCLES+1 cycles.
- All outputs are registered; no combinational path from `req` to `gnt`.
- The adder path `a_q`/`b_q` → `res_sum` is a multicycle path of ADD_CYCLES; its constraint must match the parameter.

## Structure
- Package `adder_arb_pkg` holds:
  - state enum `arb_state_t` (IDLE, BUSY);
  - default constants `PROC_SIZE_DEF`=16, `NUM_REQ_DEF`=4, `ADD_CYCLES_DEF`=2.
- One sub-module: the existing `ripple_carry_adder #(PROC_SIZE)`, instantiated as the shared datapath.
- Round-robin selection is inline, as a function over `req` and `last_id`.

## Test plan
Defaults: PROC_SIZE=16, NUM_REQ=4, ADD_CYCLES=2.

1. Assert `rst` → all outputs 0; after release with `req`=0 for 10 cycles → `gnt`=0 and `res_valid`=0 throughout.
2. `req`=4'b0010, a1=0x0001, b1=0x0002 → `gnt`=4'b0010 for one cycle; two edges later `res_valid`=1 with `res_id`=1, `res_sum`=0x0003, `res_cout`=0.
3. Overflow cases on requester 0:
   - 0xFFFF+0x0001 → `res_sum`=0x0000, `res_cout`=1;
   - 0x8000+0x8000 → `res_sum`=0x0000, `res_cout`=1;
   - 0x1111+0x1111 → `res_sum`=0x2222, `res_cout`=0.
4. All four `req` held high continuously, operands ai=i, bi=0x0010 → grant order 0,1,2,3,0; grants exactly 3 cycles apart; sums 0x0010..0x0013 with matching `res_id`.
5. `rst` pulsed during BUSY (one cycle after a `gnt` to requester 2) → no `res_valid`, `busy`=0; with all `req` high afterward, the next grant goes to requester 0.
6. `req`[3] raised and dropped during BUSY, before IDLE → requester 3 never granted; `req`[1] held → granted at the first IDLE edge.
